seq_divider: RTL

- Sequential restoring divider: the inverse datapath of the team's shift-add multiplier.
- Takes an unsigned dividend and divisor. Produces quotient and remainder over 2*WIDTH shift/subtract cycles.
- Contains its own control FSM and start/done handshake, so it drops in beside the multiplier in the arithmetic unit.

---
 rtl/seq_divider.sv | 117 +++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider with start/done handshake: WIDTH-bit quotient and remainder
// in 2*WIDTH shift/subtract cycles. Define DIV_ZERO_FAST_EN to finish divide-by-zero in one cycle.
module seq_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef DIV_ZERO_FAST_EN
    localparam bit FastDivZero = 1'b1;
`else
    localparam bit FastDivZero = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StShift, StSub, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   a_sub;

    assign a_sub = a_q - {1'b0, d_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = '0;
                    q_d     = dividend;
                    d_d     = divisor;
                    cnt_d   = CW'(WIDTH);
                    dbz_d   = (divisor == '0);
                    state_d = StShift;
                    // Load the known divide-by-zero result directly
                    if (FastDivZero && (divisor == '0)) begin
                        a_d     = {1'b0, dividend};
                        q_d     = '1;
                        state_d = StDone;
                    end
                end
            end
            StShift: begin
                // A[WIDTH] is always 0 here since the previous SUB left A < D
                a_d     = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
                q_d     = {q_q[WIDTH-2:0], 1'b0};
                state_d = StSub;
            end
            StSub: begin
                if (a_q >= {1'b0, d_q}) begin
                    a_d = a_sub;
                    q_d = {q_q[WIDTH-1:1], 1'b1};
                end
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == CW'(1)) ? StDone : StShift;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = q_q;
    assign remainder   = a_q[WIDTH-1:0];
    assign div_by_zero = dbz_q;

endmodule
